hazard_unit: RTL and testbench

Pipeline hazard and stall controller, the stage directly upstream of `forwarding_unit`. It decides when forwarding cannot resolve a dependence, or when a memory is not ready, and drives per-stage stall/flush strobes to the IF/ID/EX/MEM/WB pipeline registers. It holds small instruction-fetch and data-memory wait FSMs, remembers a redirect that arrives during a fetch wait, and keeps a saturating stall-cycle counter.

---
 rtl/forwarding_unit_pkg.sv | 11 +
 rtl/hazard_unit_pkg.sv | 26 ++
 rtl/mem_wait_fsm.sv | 44 ++++
 rtl/hazard_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/forwarding_unit_pkg.sv
// Forwarding classes shared by the hazard and forwarding units.
package forwarding_unit_pkg;

  typedef enum logic [1:0] {
    ForwardNone,
    ForwardExecute,
    ForwardExecuteMemory,
    ForwardDecode
  } forwarding_type_t;

endpackage

// File: rtl/hazard_unit_pkg.sv
// State and stall-priority types for the hazard unit and its memory wait FSMs.
package hazard_unit_pkg;

  typedef enum logic {D_IDLE, D_WAIT} dmem_state_t;
  typedef enum logic {I_IDLE, I_WAIT} imem_state_t;
  typedef enum logic {W_IDLE, W_BUSY} wait_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_IFETCH,
    CAUSE_LOADUSE,
    CAUSE_DMEM
  } stall_cause_t;

  // Data-memory wait dominates load-use, which dominates a fetch wait.
  function automatic stall_cause_t stallCause(input logic dWait, input logic loadUse,
                                              input logic iWait);
    stall_cause_t cause;
    cause = CAUSE_NONE;
    if (dWait)        cause = CAUSE_DMEM;
    else if (loadUse) cause = CAUSE_LOADUSE;
    else if (iWait)   cause = CAUSE_IFETCH;
    return cause;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Two-state req/ack tracker; wait_o marks cycles the access is still outstanding,
// done_o marks the ack that ends a multi-cycle wait.
module mem_wait_fsm
  import hazard_unit_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_i,
  input  logic ack_i,
  output logic wait_o,
  output logic done_o
);

  wait_state_t state_q, state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= W_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wait_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (req_i && !ack_i) begin
          state_d = W_BUSY;
          wait_o  = 1'b1;
        end
      end
      W_BUSY: begin
        if (ack_i) begin
          state_d = W_IDLE;
          done_o  = 1'b1;
        end else begin
          wait_o = 1'b1;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard/stall controller: load-use detection, fetch and data-memory waits,
// pending fetch redirect, and a saturating stall-cycle counter.
module hazard_unit
  import hazard_unit_pkg::*;
  import forwarding_unit_pkg::*;
#(
  parameter int N = 5,
  parameter int C = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  forwarding_type_t forwarding_type_id,
  input  logic [N-1:0]     rs1_id,
  input  logic [N-1:0]     rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [N-1:0]     rd_ex,
  input  logic [N-1:0]     rd_mem,
  input  logic             reg_we_ex,
  input  logic             reg_we_mem,
  input  logic             mem_rd_ex,
  input  logic             mem_rd_mem,
  input  logic             inst_req,
  input  logic             inst_ack,
  input  logic             mem_req_mem,
  input  logic             mem_ack,
  input  logic             branch_taken_id,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_wb,
  output logic [C-1:0]     stall_cycles
);

  localparam logic [C-1:0] CountOne = {{(C-1){1'b0}}, 1'b1};

  function automatic logic regMatch(input logic we, input logic [N-1:0] rd,
                                    input logic [N-1:0] rs, input logic used);
    return we && (rd != '0) && (rd == rs) && used;
  endfunction

  logic iWait, iDone, dWait, dDone;
  logic m1Ex, m2Ex, m1Mem, m2Mem;
  logic luLoadEx, luDecode, loadUse, stallIdInt;
  stall_cause_t cause;
  logic killPending_q, killPending_d;
  logic [C-1:0] stallCount_q, stallCount_d;

  mem_wait_fsm u_ifetch (
    .clock (clock),
    .reset (reset),
    .req_i (inst_req),
    .ack_i (inst_ack),
    .wait_o(iWait),
    .done_o(iDone)
  );

  mem_wait_fsm u_dmem (
    .clock (clock),
    .reset (reset),
    .req_i (mem_req_mem),
    .ack_i (mem_ack),
    .wait_o(dWait),
    .done_o(dDone)
  );

  // A store's rs2 comes WB->MEM, so only its rs1 can cause a load-use stall.
  always_comb begin
    m1Ex     = regMatch(reg_we_ex, rd_ex, rs1_id, rs1_used_id);
    m2Ex     = regMatch(reg_we_ex, rd_ex, rs2_id, rs2_used_id);
    m1Mem    = regMatch(reg_we_mem, rd_mem, rs1_id, rs1_used_id);
    m2Mem    = regMatch(reg_we_mem, rd_mem, rs2_id, rs2_used_id);
    luLoadEx = mem_rd_ex && (m1Ex || (m2Ex && forwarding_type_id != ForwardExecuteMemory));
    luDecode = (forwarding_type_id == ForwardDecode) &&
               ((!mem_rd_ex && (m1Ex || m2Ex)) || (mem_rd_mem && (m1Mem || m2Mem)));
    loadUse  = luLoadEx || luDecode;
    cause    = stallCause(dWait, loadUse, iWait);
    stallIdInt = (cause == CAUSE_DMEM) || (cause == CAUSE_LOADUSE);
  end

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_wb  = 1'b0;
    if (!reset) begin
      case (cause)
        CAUSE_DMEM: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          flush_wb  = 1'b1;
        end
        CAUSE_LOADUSE: begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
        CAUSE_IFETCH: begin
          stall_if = 1'b1;
          flush_id = 1'b1;
        end
        default: flush_id = branch_taken_id || (killPending_q && inst_ack);
      endcase
    end
  end

  // A redirect seen mid-fetch must still squash the instruction that fetch returns.
  always_comb begin
    killPending_d = killPending_q;
    if (iDone)
      killPending_d = 1'b0;
    else if (branch_taken_id && iWait && !stallIdInt)
      killPending_d = 1'b1;
    stallCount_d = stallCount_q;
    if (stall_if && stallCount_q != '1)
      stallCount_d = stallCount_q + CountOne;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      killPending_q <= 1'b0;
      stallCount_q  <= '0;
    end else begin
      killPending_q <= killPending_d;
      stallCount_q  <= stallCount_d;
    end
  end

  assign stall_cycles = stallCount_q;

  assert property (@(posedge clock) disable iff (reset) !(iDone && iWait) && !(dDone && dWait));

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit; stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_unit;
  import forwarding_unit_pkg::*;

  localparam int N = 5;
  localparam int C = 5;
  localparam logic [C-1:0] MaxCount = '1;

  // Expected vectors: {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100010;
  localparam logic [6:0] IW   = 7'b1000100;
  localparam logic [6:0] DW   = 7'b1111001;
  localparam logic [6:0] FID  = 7'b0000100;

  logic clock, reset;
  forwarding_type_t forwarding_type_id;
  logic [N-1:0] rs1_id, rs2_id, rd_ex, rd_mem;
  logic rs1_used_id, rs2_used_id, reg_we_ex, reg_we_mem, mem_rd_ex, mem_rd_mem;
  logic inst_req, inst_ack, mem_req_mem, mem_ack, branch_taken_id;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb;
  logic [C-1:0] stall_cycles;

  typedef struct {
    string        name;
    logic [6:0]   outs;
    logic [C-1:0] count;
  } exp_t;

  exp_t expQ[$];
  int vectors = 0;
  int miscompares = 0;
  logic [C-1:0] expCount = '0;

  hazard_unit #(.N(N), .C(C)) dut (
    .clock(clock), .reset(reset), .forwarding_type_id(forwarding_type_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .reg_we_ex(reg_we_ex), .reg_we_mem(reg_we_mem),
    .mem_rd_ex(mem_rd_ex), .mem_rd_mem(mem_rd_mem), .inst_req(inst_req), .inst_ack(inst_ack),
    .mem_req_mem(mem_req_mem), .mem_ack(mem_ack), .branch_taken_id(branch_taken_id),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_wb(flush_wb), .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    forwarding_type_id = ForwardNone;
    rs1_id = '0; rs2_id = '0; rd_ex = '0; rd_mem = '0;
    rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    reg_we_ex = 1'b0; reg_we_mem = 1'b0; mem_rd_ex = 1'b0; mem_rd_mem = 1'b0;
    inst_req = 1'b0; inst_ack = 1'b0; mem_req_mem = 1'b0; mem_ack = 1'b0;
    branch_taken_id = 1'b0;
  endtask

  // The counter seen this cycle reflects only earlier stall_if cycles.
  task automatic applyStimulus(input string name, input logic [6:0] outs);
    exp_t e;
    e.name  = name;
    e.outs  = outs;
    e.count = expCount;
    expQ.push_back(e);
    if (!reset && outs[6])
      expCount = (expCount == MaxCount) ? MaxCount : expCount + C'(1);
  endtask

  task automatic loadInEx(input logic [N-1:0] rd);
    rd_ex = rd; reg_we_ex = 1'b1; mem_rd_ex = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        act = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb};
        vectors++;
        if (act !== e.outs || stall_cycles !== e.count) begin
          miscompares++;
          $display("[TB] FAIL %s: outs=%b cycles=%0d, expected outs=%b cycles=%0d",
                   e.name, act, stall_cycles, e.outs, e.count);
        end
      end
    end
  end

  initial begin : stimulus
    clearInputs();
    reset = 1'b1;
    nextCycle(); mem_req_mem = 1'b1; applyStimulus("reset_gate", NONE);
    nextCycle(); reset = 1'b0; clearInputs(); applyStimulus("idle", NONE);

    // Load x5 in EX feeding an ADD, then the load in MEM is forwarded.
    nextCycle(); clearInputs(); forwarding_type_id = ForwardExecute;
    rs1_id = 5'd5; rs1_used_id = 1'b1; loadInEx(5'd5); applyStimulus("lu_rs1", LU);
    nextCycle(); clearInputs(); forwarding_type_id = ForwardExecute;
    rs1_id = 5'd5; rs1_used_id = 1'b1; rd_mem = 5'd5; reg_we_mem = 1'b1; mem_rd_mem = 1'b1;
    applyStimulus("after_bubble", NONE);

    // Store: rs2 dependence forwards, rs1 dependence stalls.
    nextCycle(); clearInputs(); forwarding_type_id = ForwardExecuteMemory;
    rs1_id = 5'd1; rs1_used_id = 1'b1; rs2_id = 5'd5; rs2_used_id = 1'b1; loadInEx(5'd5);
    applyStimulus("store_rs2", NONE);
    nextCycle(); clearInputs(); forwarding_type_id = ForwardExecuteMemory;
    rs1_id = 5'd5; rs1_used_id = 1'b1; loadInEx(5'd5); applyStimulus("store_rs1", LU);

    // BEQ resolved in decode after a load: two stalls then the branch flush.
    nextCycle(); clearInputs(); forwarding_type_id = ForwardDecode;
    rs1_id = 5'd7; rs1_used_id = 1'b1; loadInEx(5'd7); applyStimulus("beq_ex", LU);
    nextCycle(); clearInputs(); forwarding_type_id = ForwardDecode;
    rs1_id = 5'd7; rs1_used_id = 1'b1; rd_mem = 5'd7; reg_we_mem = 1'b1; mem_rd_mem = 1'b1;
    applyStimulus("beq_mem", LU);
    nextCycle(); clearInputs(); forwarding_type_id = ForwardDecode;
    rs1_id = 5'd7; rs1_used_id = 1'b1; branch_taken_id = 1'b1; applyStimulus("beq_branch", FID);
    nextCycle(); clearInputs(); forwarding_type_id = ForwardDecode;
    rs2_id = 5'd9; rs2_used_id = 1'b1; rd_ex = 5'd9; reg_we_ex = 1'b1;
    applyStimulus("beq_alu_ex", LU);
    nextCycle(); clearInputs(); forwarding_type_id = ForwardExecute;
    rs1_id = 5'd0; rs1_used_id = 1'b1; loadInEx(5'd0); applyStimulus("rd_x0", NONE);

    // Data access acknowledged three cycles late, then a same-cycle ack.
    for (int i = 0; i < 3; i++) begin
      nextCycle(); clearInputs(); mem_req_mem = 1'b1; applyStimulus("dmem_wait", DW);
    end
    nextCycle(); clearInputs(); mem_req_mem = 1'b1; mem_ack = 1'b1; applyStimulus("dmem_ack", NONE);
    nextCycle(); clearInputs(); mem_req_mem = 1'b1; mem_ack = 1'b1; applyStimulus("dmem_zero", NONE);

    // Data wait outranks load-use; load-use shows once the ack arrives.
    nextCycle(); clearInputs(); mem_req_mem = 1'b1; forwarding_type_id = ForwardExecute;
    rs1_id = 5'd3; rs1_used_id = 1'b1; loadInEx(5'd3); applyStimulus("dmem_over_lu", DW);
    nextCycle(); clearInputs(); mem_req_mem = 1'b1; mem_ack = 1'b1; forwarding_type_id = ForwardExecute;
    rs1_id = 5'd3; rs1_used_id = 1'b1; loadInEx(5'd3); applyStimulus("lu_after_ack", LU);

    // Fetch waits four cycles with a redirect in the second.
    nextCycle(); clearInputs(); inst_req = 1'b1; applyStimulus("ifetch_req", IW);
    nextCycle(); clearInputs(); inst_req = 1'b1; branch_taken_id = 1'b1;
    applyStimulus("ifetch_branch", IW);
    nextCycle(); clearInputs(); inst_req = 1'b1; applyStimulus("ifetch_wait", IW);
    nextCycle(); clearInputs(); inst_req = 1'b1; applyStimulus("ifetch_wait2", IW);
    nextCycle(); clearInputs(); inst_req = 1'b1; inst_ack = 1'b1; applyStimulus("ifetch_ack_kill", FID);
    nextCycle(); clearInputs(); inst_ack = 1'b1; applyStimulus("kill_cleared", NONE);

    nextCycle(); clearInputs(); forwarding_type_id = ForwardExecute; branch_taken_id = 1'b1;
    rs1_id = 5'd4; rs1_used_id = 1'b1; loadInEx(5'd4); applyStimulus("branch_under_lu", LU);

    // Long data wait drives the counter into saturation.
    for (int i = 0; i < 20; i++) begin
      nextCycle(); clearInputs(); mem_req_mem = 1'b1; applyStimulus("dmem_sat", DW);
    end
    nextCycle(); clearInputs(); mem_req_mem = 1'b1; mem_ack = 1'b1; applyStimulus("sat_hold", NONE);

    // Reset in the middle of a data wait.
    nextCycle(); clearInputs(); mem_req_mem = 1'b1; applyStimulus("dmem_pre_reset", DW);
    nextCycle(); reset = 1'b1; expCount = '0; applyStimulus("reset_in_dwait", NONE);
    nextCycle(); reset = 1'b0; clearInputs(); applyStimulus("dmem_idle_after_reset", NONE);

    // Reset drops a pending redirect.
    nextCycle(); clearInputs(); inst_req = 1'b1; applyStimulus("ifetch_req2", IW);
    nextCycle(); clearInputs(); inst_req = 1'b1; branch_taken_id = 1'b1;
    applyStimulus("ifetch_branch2", IW);
    nextCycle(); reset = 1'b1; expCount = '0; applyStimulus("reset_in_iwait", NONE);
    nextCycle(); reset = 1'b0; clearInputs(); inst_ack = 1'b1; applyStimulus("kill_lost", NONE);

    nextCycle(); clearInputs();
    repeat (3) @(negedge clock);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d vectors unchecked, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
